// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues imem reads and queues returned words for decode.
// Optional `IFETCH_BYPASS_EN: a word returning to an empty queue is presented to decode in the same cycle.
module ifetch_queue #(
    parameter int          DEPTH   = 2,
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_npc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_BOOT    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   old_addr_q, old_addr_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic full, fifo_valid, live, take, byp, push, pop;

    assign full       = (count_q == CW'(DEPTH));
    assign fifo_valid = (count_q != '0);
    assign live       = !halt && !redirect;

    always_comb begin
        imemREN  = 1'b0;
        imemaddr = fetch_pc_q;
        case (state_q)
            S_RUN:     imemREN = !full;
            S_DISCARD: begin
                imemREN  = 1'b1;
                imemaddr = old_addr_q;
            end
            default:   imemREN = 1'b0;
        endcase
    end

    assign take = (state_q == S_RUN) && imemREN && ihit;

`ifdef IFETCH_BYPASS_EN
    assign byp = take && !fifo_valid && live;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        inst       = 32'h0;
        inst_pc    = last_pc_q;
        inst_valid = fifo_valid | byp;
        if (fifo_valid) begin
            inst    = fifo_inst_q[head_q];
            inst_pc = fifo_pc_q[head_q];
        end else if (byp) begin
            inst    = imemload;
            inst_pc = fetch_pc_q;
        end
    end

    assign inst_npc = inst_pc + 32'd4;

    // A bypassed word taken by decode this cycle never enters the queue.
    assign pop  = fifo_valid && inst_ready && live;
    assign push = take && live && !(byp && inst_ready);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        old_addr_d = old_addr_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        last_pc_d  = inst_valid ? inst_pc : last_pc_q;
        if (state_q != S_HALTED) begin
            if (halt) begin
                state_d = S_HALTED;
                count_d = '0;
                head_d  = '0;
                tail_d  = '0;
            end else if (redirect) begin
                count_d    = '0;
                head_d     = '0;
                tail_d     = '0;
                fetch_pc_d = redirect_addr & ~32'h3;
                case (state_q)
                    S_RUN: begin
                        // Outstanding read must still be consumed before the new address goes out.
                        if (imemREN && !ihit) begin
                            state_d    = S_DISCARD;
                            old_addr_d = fetch_pc_q;
                        end
                    end
                    S_DISCARD: if (ihit) state_d = S_RUN;
                    default:   state_d = S_RUN;
                endcase
            end else begin
                case (state_q)
                    S_BOOT:    state_d = S_RUN;
                    S_DISCARD: if (ihit) state_d = S_RUN;
                    default: begin
                        if (take) fetch_pc_d = fetch_pc_q + 32'd4;
                        if (push) tail_d = tail_q + 1'b1;
                        if (pop)  head_d = head_q + 1'b1;
                        count_d = count_q + CW'(push) - CW'(pop);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= S_BOOT;
            fetch_pc_q <= PC_INIT;
            old_addr_q <= PC_INIT;
            last_pc_q  <= 32'h0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            old_addr_q <= old_addr_d;
            last_pc_q  <= last_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_inst_q[tail_q] <= imemload;
            fifo_pc_q[tail_q]   <= fetch_pc_q;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: driver issues vectors and queues expected words, monitor checks every pop.
module tb_ifetch_queue;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic [31:0] inst, inst_pc, inst_npc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb [$];

    ifetch_queue #(.DEPTH(2), .PC_INIT(32'h0)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .inst(inst), .inst_pc(inst_pc),
        .inst_npc(inst_npc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ren"},   {31'h0, imemREN},    32'h0);
        chk({tag, "_addr"},  imemaddr,            32'h0);
        chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
        chk({tag, "_inst"},  inst,                32'h0);
        chk({tag, "_pc"},    inst_pc,             32'h0);
        chk({tag, "_npc"},   inst_npc,            32'h4);
    endtask

    // Monitor: every accepted head must match the oldest expected word (memory returns addr as data).
    always @(negedge CLK) begin
        if (nRST === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h expected none", inst_pc);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("pop_inst", inst, e);
                chk("pop_pc", inst_pc, e);
                chk("pop_npc", inst_npc, e + 32'd4);
            end
        end
    end

    initial begin
        nRST = 1'b1; ihit = 1'b0; imemload = 32'h0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_addr = 32'h0; halt = 1'b0;
        #2 nRST = 1'b0;
        #1 chk_reset("reset");
        tick(); tick();
        nRST = 1'b1;
        tick();
        chk("boot_exit_ren", {31'h0, imemREN}, 32'h1);
        chk("boot_exit_valid", {31'h0, inst_valid}, 32'h0);

        // streaming fetch, decode always ready
        for (int i = 0; i < 6; i++) begin
            chk("stream_addr", imemaddr, 32'(4 * i));
            chk("stream_ren", {31'h0, imemREN}, 32'h1);
            ihit = 1'b1; inst_ready = 1'b1; imemload = imemaddr;
            sb.push_back(32'(4 * i));
            tick();
            chk("stream_valid", {31'h0, inst_valid}, 32'h1);
        end
        ihit = 1'b0;
        tick();
        chk("empty_valid", {31'h0, inst_valid}, 32'h0);
        chk("empty_inst", inst, 32'h0);
        chk("empty_pc_hold", inst_pc, 32'h14);
        chk("empty_npc_hold", inst_npc, 32'h18);

        // fill to DEPTH with decode stalled
        inst_ready = 1'b0; ihit = 1'b1; imemload = imemaddr; sb.push_back(32'h18);
        tick();
        chk("fill1_addr", imemaddr, 32'h1c);
        chk("fill1_ren", {31'h0, imemREN}, 32'h1);
        imemload = imemaddr; sb.push_back(32'h1c);
        tick();
        chk("full_ren", {31'h0, imemREN}, 32'h0);
        chk("full_addr", imemaddr, 32'h20);
        imemload = imemaddr;
        tick();
        chk("full_hold_ren", {31'h0, imemREN}, 32'h0);
        chk("full_hold_addr", imemaddr, 32'h20);
        chk("full_head", inst, 32'h18);

        // release stall, resume at 0x20 with simultaneous push/pop
        inst_ready = 1'b1; ihit = 1'b0;
        tick();
        chk("resume_ren", {31'h0, imemREN}, 32'h1);
        chk("resume_addr", imemaddr, 32'h20);
        ihit = 1'b1; imemload = imemaddr; sb.push_back(32'h20);
        tick();
        chk("pushpop_ren", {31'h0, imemREN}, 32'h1);
        chk("pushpop_addr", imemaddr, 32'h24);
        chk("pushpop_head", inst_pc, 32'h20);
        ihit = 1'b0;
        tick();
        chk("drain_valid", {31'h0, inst_valid}, 32'h0);

        // redirect while a request is outstanding
        redirect = 1'b1; redirect_addr = 32'h40;
        tick();
        chk("disc_ren", {31'h0, imemREN}, 32'h1);
        chk("disc_addr", imemaddr, 32'h24);
        chk("disc_valid", {31'h0, inst_valid}, 32'h0);
        redirect = 1'b0;
        tick();
        chk("disc_hold_addr", imemaddr, 32'h24);
        ihit = 1'b1; imemload = imemaddr;
        tick();
        chk("disc_drop_valid", {31'h0, inst_valid}, 32'h0);
        chk("disc_new_addr", imemaddr, 32'h40);
        imemload = imemaddr; sb.push_back(32'h40);
        tick();
        chk("redir_first_pc", inst_pc, 32'h40);
        ihit = 1'b0;
        tick();

        // redirect coincident with ihit, misaligned target
        ihit = 1'b1; imemload = imemaddr; redirect = 1'b1; redirect_addr = 32'h103;
        tick();
        chk("rhit_valid", {31'h0, inst_valid}, 32'h0);
        chk("rhit_addr", imemaddr, 32'h100);
        chk("rhit_ren", {31'h0, imemREN}, 32'h1);
        redirect = 1'b0; imemload = imemaddr; sb.push_back(32'h100);
        tick();
        chk("rhit_next_pc", inst_pc, 32'h100);
        ihit = 1'b0;
        tick();

        // PC wrap at top of address space
        ihit = 1'b1; imemload = imemaddr; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        chk("wrap_addr_top", imemaddr, 32'hFFFF_FFFC);
        redirect = 1'b0; imemload = imemaddr; sb.push_back(32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", imemaddr, 32'h0);
        chk("wrap_npc", inst_npc, 32'h0);
        ihit = 1'b0;
        tick();

        // halt + redirect with two entries queued
        inst_ready = 1'b0; ihit = 1'b1; imemload = imemaddr;
        tick();
        imemload = imemaddr;
        tick();
        chk("prehalt_valid", {31'h0, inst_valid}, 32'h1);
        chk("prehalt_ren", {31'h0, imemREN}, 32'h0);
        halt = 1'b1; redirect = 1'b1; redirect_addr = 32'h200; ihit = 1'b0;
        tick();
        chk("halt_valid", {31'h0, inst_valid}, 32'h0);
        chk("halt_ren", {31'h0, imemREN}, 32'h0);
        halt = 1'b0; redirect = 1'b0; inst_ready = 1'b1; ihit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halted_ren", {31'h0, imemREN}, 32'h0);
            chk("halted_valid", {31'h0, inst_valid}, 32'h0);
        end
        redirect = 1'b1; redirect_addr = 32'h300;
        tick();
        chk("halted_redir_ren", {31'h0, imemREN}, 32'h0);
        redirect = 1'b0; ihit = 1'b0;

        // asynchronous reset pulse mid-cycle
        #2 nRST = 1'b0;
        #1 chk_reset("rst_pulse");
        tick();
        nRST = 1'b1;
        tick();
        chk("rerun_ren", {31'h0, imemREN}, 32'h1);
        chk("rerun_addr", imemaddr, 32'h0);

        chk("sb_leftover", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage directly upstream of the single-cycle decode controller.
- Owns the fetch PC and drives instruction-memory read requests.
- Buffers returned words in a small FIFO and presents instruction, PC and PC+4 to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/jr targets) and a sticky halt from decode.

Parameters:
DEPTH, 2, FIFO entries (power of two, 2..8)
PC_INIT, 32'h0000_0000, fetch PC after reset

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  asynchronous active-low reset
imemREN  out  1  instruction read request
imemaddr  out  32  word address of request
ihit  in  1  read data valid this cycle
imemload  in  32  read data
inst  out  32  head instruction, 32'h0 when empty
inst_pc  out  32  PC of head instruction
inst_npc  out  32  inst_pc + 4 (consumed by JAL link path)
inst_valid  out  1  head entry valid
inst_ready  in  1  decode accepts head this cycle
redirect  in  1  flush and refetch from redirect_addr
redirect_addr  in  32  new fetch PC (low 2 bits ignored, forced 0)
halt  in  1  stop fetching permanently

Behaviour:
- Reset (nRST low, async): state BOOT, fetch_pc=PC_INIT, count=0, discard=0; imemREN=0, imemaddr=PC_INIT, inst_valid=0, inst=0, inst_pc=0, inst_npc=4.
- FSM states BOOT, RUN, DISCARD, HALTED.
- BOOT: transitions to RUN on the first edge after reset release; imemREN=0.
- RUN:
  - imemREN = (count < DEPTH); imemaddr = fetch_pc.
  - imemaddr is held stable while imemREN=1 and ihit=0.
- Push:
  - Occurs when in RUN with imemREN & ihit.
  - Entry {imemload, fetch_pc} is written at tail; fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC -> 0).
- Pop: occurs when inst_valid & inst_ready; head advances.
- Simultaneous push and pop leaves count unchanged.
- Full (count==DEPTH): imemREN=0. Since a request is only raised when not full, a push can never hit a full FIFO.
- Empty: inst_valid=0, inst=0; inst_pc/inst_npc hold last values.
- Latency: ihit in cycle n -> inst_valid in cycle n+1.
- Redirect (any state except HALTED):
  - FIFO flushed (count=0); a pop in the same cycle is ignored.
  - fetch_pc <= {redirect_addr[31:2],2'b00}.
  - If a request is outstanding (imemREN=1, ihit=0): go to DISCARD and keep imemaddr at the old address.
  - If ihit arrives in the same cycle: drop the data and stay in RUN.
- DISCARD:
  - imemREN=1, imemaddr=old address; inst_valid=0.
  - On ihit, drop the data and go to RUN; the new address is requested in the next cycle.
  - A further redirect while in DISCARD only updates fetch_pc.
- Halt:
  - Wins over redirect and push in the same cycle.
  - Next state HALTED: flush FIFO, imemREN=0, inst_valid=0.
  - HALTED exits only via nRST.
  - A pending response arriving after halt is ignored.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
IFETCH_BYPASS_EN
- Defined:
  - When count==0 and ihit in RUN with no redirect/halt, imemload/fetch_pc drive inst/inst_pc directly with inst_valid=1 in the same cycle.
  - If inst_ready=1, the word is consumed without being written.
  - Otherwise it is pushed as normal.
  - Latency is 0 cycles.
- Undefined: no combinational path from ihit/imemload to outputs; latency is 1 cycle.

Test Plan:
- Reset release, ihit=1 every cycle with imemload=addr, inst_ready=1 -> imemaddr 0,4,8...; inst_valid from cycle 2 (cycle 1 with IFETCH_BYPASS_EN) with inst=0,4,8, inst_npc=inst_pc+4.
- inst_ready=0, ihit=1 continuously, DEPTH=2 -> two pushes (PC 0,4), then imemREN=0, imemaddr holds 8.
- inst_ready=1 raised after that -> imemREN returns, fetch resumes at 8.
- Mid-request redirect: imemREN=1, ihit=0, redirect to 0x40 -> imemaddr stays at old PC until ihit, that data is dropped, next request is 0x40, first valid inst_pc=0x40.
- Redirect coincident with ihit, redirect_addr=0x103 -> data dropped, FIFO empty, next imemaddr=0x100.
- halt and redirect asserted together with 2 entries queued -> inst_valid=0, imemREN=0 permanently; later ihit ignored.
- nRST pulsed low -> outputs immediately at reset values.
- fetch_pc=0xFFFFFFFC, ihit -> next imemaddr=0x0.
